// File: rtl/smvm_result_rx.sv
// Receives the SMVM result stream as hi/lo half pairs, rebuilds each signed row
// result, tags it with row index and last flag, and buffers it for a ready/valid sink.
module smvm_result_rx #(
    parameter int DEPTH  = 8,
    parameter int HALF_W = 14
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [7:0]            rows,
    input  logic                  smvm_valid,
    input  logic [HALF_W-1:0]     smvm_data,
    output logic                  res_valid,
    input  logic                  res_ready,
    output logic [2*HALF_W-1:0]   res_data,
    output logic [7:0]            res_row,
    output logic                  res_last,
    output logic                  busy,
    output logic                  done,
    output logic                  overflow,
    output logic                  stray
);
    localparam int AW    = $clog2(DEPTH);
    localparam int RES_W = 2 * HALF_W;
    localparam int ENT_W = 8 + 1 + RES_W;

    typedef enum logic [1:0] {IDLE, WAIT_HI, WAIT_LO, FLUSH} state_t;

    state_t              state_reg;
    logic [7:0]          rows_reg;
    logic [7:0]          row_idx_reg;
    logic [HALF_W-1:0]   hi_reg;
    logic                pend_valid_reg;
    logic [ENT_W-1:0]    pend_entry_reg;
    logic [ENT_W-1:0]    mem [DEPTH];
    logic [AW-1:0]       wr_ptr_reg;
    logic [AW-1:0]       rd_ptr_reg;
    logic [AW:0]         count_reg;
    logic                done_reg;
    logic                overflow_reg;
    logic                stray_reg;

    logic                full;
    logic                pop;
    logic                push_ok;
    logic                is_last_row;
    logic [ENT_W-1:0]    head;

    assign full        = (count_reg == (AW+1)'(DEPTH));
    assign res_valid   = (count_reg != '0);
    assign pop         = res_valid && res_ready;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts the push.
    assign push_ok     = pend_valid_reg && (!full || pop);
    assign is_last_row = (row_idx_reg == rows_reg - 8'd1);

    assign head     = mem[rd_ptr_reg];
    assign res_data = res_valid ? head[RES_W-1:0] : '0;
    assign res_last = res_valid && head[RES_W];
    assign res_row  = res_valid ? head[ENT_W-1 -: 8] : '0;
    assign busy     = (state_reg != IDLE);
    assign done     = done_reg;
    assign overflow = overflow_reg;
    assign stray    = stray_reg;

    always_ff @(posedge clk) begin
        if (push_ok)
            mem[wr_ptr_reg] <= pend_entry_reg;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg      <= IDLE;
            rows_reg       <= '0;
            row_idx_reg    <= '0;
            hi_reg         <= '0;
            pend_valid_reg <= 1'b0;
            pend_entry_reg <= '0;
            wr_ptr_reg     <= '0;
            rd_ptr_reg     <= '0;
            count_reg      <= '0;
            done_reg       <= 1'b0;
            overflow_reg   <= 1'b0;
            stray_reg      <= 1'b0;
        end else begin
            done_reg       <= 1'b0;
            pend_valid_reg <= 1'b0;

            if (push_ok)
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (pop)
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            count_reg <= count_reg + (AW+1)'(push_ok) - (AW+1)'(pop);
            if (pend_valid_reg && !push_ok)
                overflow_reg <= 1'b1;

            case (state_reg)
                IDLE: begin
                    if (start) begin
                        rows_reg     <= rows;
                        row_idx_reg  <= '0;
                        overflow_reg <= 1'b0;
                        stray_reg    <= 1'b0;
                        if (rows != 8'd0)
                            state_reg <= WAIT_HI;
                        else
                            done_reg <= 1'b1;
                    end
                    if (smvm_valid)
                        stray_reg <= 1'b1;
                end
                WAIT_HI: begin
                    if (smvm_valid) begin
                        hi_reg    <= smvm_data;
                        state_reg <= WAIT_LO;
                    end
                end
                WAIT_LO: begin
                    if (smvm_valid) begin
                        pend_valid_reg <= 1'b1;
                        pend_entry_reg <= {row_idx_reg, is_last_row, hi_reg, smvm_data};
                        if (is_last_row) begin
                            state_reg <= FLUSH;
                        end else begin
                            row_idx_reg <= row_idx_reg + 8'd1;
                            state_reg   <= WAIT_HI;
                        end
                    end
                end
                FLUSH: begin
                    if (smvm_valid)
                        stray_reg <= 1'b1;
                    // The staged last entry must land before the FIFO counts as drained.
                    if (count_reg == '0 && !pend_valid_reg) begin
                        state_reg <= IDLE;
                        done_reg  <= 1'b1;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end
endmodule
